// File: rtl/alu_exec_if.sv
// Bundle of instruction/operand inputs and decode/ALU outputs for alu_exec_core.
// master drives the instruction and register read data; slave is the execute core.
interface alu_exec_if;
    logic [8:0] instr;
    logic       instr_valid;
    logic [7:0] rdat_a;
    logic [7:0] rdat_b;
    logic [1:0] r_addr1;
    logic [1:0] r_addr2;
    logic [1:0] w_addr;
    logic       reg_write;
    logic [7:0] result;
    logic       carry;
    logic       mem_write;
    logic       mem_to_reg;
    logic [3:0] lut_index;
    logic       lut_write;
    logic       lut_sel;
    logic       lut_to_reg;
    logic       branch_enable;
    logic [4:0] branch_index;
    logic       equal;
    logic       less_than;

    modport master (
        output instr, instr_valid, rdat_a, rdat_b,
        input  r_addr1, r_addr2, w_addr, reg_write, result, carry,
               mem_write, mem_to_reg, lut_index, lut_write, lut_sel,
               lut_to_reg, branch_enable, branch_index, equal, less_than
    );

    modport slave (
        input  instr, instr_valid, rdat_a, rdat_b,
        output r_addr1, r_addr2, w_addr, reg_write, result, carry,
               mem_write, mem_to_reg, lut_index, lut_write, lut_sel,
               lut_to_reg, branch_enable, branch_index, equal, less_than
    );
endinterface

// File: rtl/alu_exec_core.sv
// Combinational decode, operand select and 8-bit ALU with registered compare flags.
// Define SIGNED_CMP_EN for two's-complement SLT/SLTE/less_than; default is unsigned.
module alu_exec_core (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);
    localparam logic [1:0] T_R = 2'b00;
    localparam logic [1:0] T_M = 2'b01;
    localparam logic [1:0] T_B = 2'b10;
    localparam logic [1:0] T_S = 2'b11;

    logic [1:0] itype;
    logic [2:0] op3;
    logic [1:0] op2;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic       lt_cmp;
    logic       eq_cmp;
    logic       flag_op;
    logic       en_ok;
    logic [7:0] sh_amt;
    logic       sh_big;
    logic [7:0] lstage [0:3];
    logic [7:0] rstage [0:3];
    logic       equal_reg;
    logic       less_than_reg;

    logic [1:0] r_addr1, r_addr2, w_addr;
    logic       reg_write, mem_write, lut_write, take;
    logic       mem_to_reg, lut_to_reg, lut_sel, carry;
    logic [7:0] result;
    logic [3:0] lut_index;
    logic [4:0] branch_index;

    assign itype = bus.instr[8:7];
    assign op3   = bus.instr[6:4];
    assign op2   = bus.instr[6:5];
    assign a     = bus.rdat_a;
    assign b     = bus.rdat_b;
    assign sum9  = {1'b0, a} + {1'b0, b};
    assign diff9 = {1'b0, a} - {1'b0, b};
    assign eq_cmp = (a == b);
`ifdef SIGNED_CMP_EN
    assign lt_cmp = $signed(a) < $signed(b);
`else
    assign lt_cmp = a < b;
`endif
    assign flag_op = (itype == T_R) && op3[2];
    assign en_ok   = bus.instr_valid && !reset;

    // Shift amount: register B for LSL/LSR, zero-extended 5-bit immediate for LSI/RSI
    assign sh_amt = op2[1] ? {3'b000, bus.instr[4:0]} : b;
    assign sh_big = |sh_amt[7:3];

    assign lstage[0] = a;
    assign rstage[0] = a;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_shift
            assign lstage[gi+1] = sh_amt[gi] ? {lstage[gi][7-(2**gi):0], {(2**gi){1'b0}}}
                                             : lstage[gi];
            assign rstage[gi+1] = sh_amt[gi] ? {{(2**gi){1'b0}}, rstage[gi][7:(2**gi)]}
                                             : rstage[gi];
        end
    endgenerate

    always_comb begin
        r_addr1      = 2'd0;
        r_addr2      = 2'd0;
        w_addr       = 2'd0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        lut_write    = 1'b0;
        take         = 1'b0;
        mem_to_reg   = 1'b0;
        lut_to_reg   = 1'b0;
        lut_sel      = 1'b0;
        carry        = 1'b0;
        result       = 8'h00;
        lut_index    = 4'h0;
        branch_index = 5'h00;
        case (itype)
            T_R: begin
                r_addr1   = bus.instr[3:2];
                w_addr    = bus.instr[3:2];
                r_addr2   = bus.instr[1:0];
                reg_write = 1'b1;
                case (op3)
                    3'b000: result = a & b;
                    3'b001: result = a | b;
                    3'b010: result = a ^ b;
                    3'b011: {carry, result} = sum9;
                    3'b100: {carry, result} = diff9;
                    3'b101: result = {7'd0, lt_cmp};
                    3'b110: result = {7'd0, lt_cmp | eq_cmp};
                    default: result = {7'd0, eq_cmp};
                endcase
            end
            T_M: begin
                case (op3)
                    3'b000: begin
                        mem_write = 1'b1;
                        r_addr1   = bus.instr[3:2];
                        r_addr2   = bus.instr[1:0];
                    end
                    3'b001: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 1'b1;
                        w_addr     = bus.instr[3:2];
                        r_addr1    = bus.instr[1:0];
                    end
                    3'b010, 3'b011: begin
                        lut_write = 1'b1;
                        lut_sel   = op3[0];
                        lut_index = bus.instr[3:0];
                    end
                    3'b100, 3'b101: begin
                        reg_write = 1'b1;
                        r_addr1   = 2'd3;
                        w_addr    = 2'd3;
                        result    = op3[0] ? {bus.instr[3:0], a[3:0]}
                                           : {a[7:4], bus.instr[3:0]};
                    end
                    3'b110: begin
                        reg_write  = 1'b1;
                        lut_to_reg = 1'b1;
                        w_addr     = bus.instr[3:2];
                    end
                    default: ;
                endcase
            end
            T_B: begin
                branch_index = bus.instr[4:0];
                case (op2)
                    2'b00:   take = equal_reg;
                    2'b01:   take = less_than_reg;
                    2'b10:   take = equal_reg | less_than_reg;
                    default: take = 1'b1;
                endcase
            end
            default: begin
                reg_write = 1'b1;
                if (op2[1]) begin
                    r_addr1 = 2'd3;
                    w_addr  = 2'd3;
                end else begin
                    r_addr1 = bus.instr[4:3];
                    w_addr  = bus.instr[4:3];
                    r_addr2 = bus.instr[2:1];
                end
                if (!sh_big)
                    result = op2[0] ? rstage[3] : lstage[3];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            equal_reg     <= 1'b0;
            less_than_reg <= 1'b0;
        end else if (bus.instr_valid && flag_op) begin
            equal_reg     <= eq_cmp;
            less_than_reg <= lt_cmp;
        end
    end

    assign bus.r_addr1       = r_addr1;
    assign bus.r_addr2       = r_addr2;
    assign bus.w_addr        = w_addr;
    assign bus.reg_write     = reg_write & en_ok;
    assign bus.mem_write     = mem_write & en_ok;
    assign bus.lut_write     = lut_write & en_ok;
    assign bus.branch_enable = take & en_ok;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.lut_to_reg    = lut_to_reg;
    assign bus.lut_sel       = lut_sel;
    assign bus.lut_index     = lut_index;
    assign bus.carry         = carry;
    assign bus.result        = result;
    assign bus.branch_index  = branch_index;
    assign bus.equal         = equal_reg;
    assign bus.less_than     = less_than_reg;
endmodule

// File: tb/tb_alu_exec_core.sv
// Self-checking bench for alu_exec_core: directed cases plus randomized vectors
// against an arithmetic reference model of the instruction set.
module tb_alu_exec_core;
    typedef struct packed {
        logic [1:0] r_addr1;
        logic [1:0] r_addr2;
        logic [1:0] w_addr;
        logic       reg_write;
        logic [7:0] result;
        logic       carry;
        logic       mem_write;
        logic       mem_to_reg;
        logic [3:0] lut_index;
        logic       lut_write;
        logic       lut_sel;
        logic       lut_to_reg;
        logic       branch_enable;
        logic [4:0] branch_index;
    } out_t;

    logic clk;
    logic reset;
    alu_exec_if bus ();

    alu_exec_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    logic m_eq  = 1'b0;
    logic m_lt  = 1'b0;
    out_t exp_o;
    out_t act_o;
    logic [8:0] cur_instr;
    logic [7:0] cur_a, cur_b;
    logic       cur_valid, cur_rst;

    function automatic logic cmp_lt(logic [7:0] a, logic [7:0] b);
        int sa, sb;
        sa = a;
        sb = b;
`ifdef SIGNED_CMP_EN
        if (sa > 127) sa = sa - 256;
        if (sb > 127) sb = sb - 256;
`endif
        return sa < sb;
    endfunction

    // Reference: what each instruction should produce, from the ISA rules
    function automatic out_t model(logic [8:0] ins, logic [7:0] a, logic [7:0] b,
                                   logic feq, logic flt, logic valid, logic rst);
        out_t o;
        int   ai, bi, amt;
        logic en, lt, eq;
        o  = '0;
        ai = a;
        bi = b;
        en = valid && !rst;
        lt = cmp_lt(a, b);
        eq = (ai == bi);
        case (ins[8:7])
            2'd0: begin
                o.r_addr1 = ins[3:2]; o.w_addr = ins[3:2]; o.r_addr2 = ins[1:0];
                o.reg_write = 1'b1;
                case (ins[6:4])
                    3'd0: o.result = a & b;
                    3'd1: o.result = a | b;
                    3'd2: o.result = a ^ b;
                    3'd3: begin o.result = 8'((ai + bi) % 256); o.carry = (ai + bi) > 255; end
                    3'd4: begin o.result = 8'((ai - bi + 256) % 256); o.carry = ai < bi; end
                    3'd5: o.result = lt ? 8'd1 : 8'd0;
                    3'd6: o.result = (lt || eq) ? 8'd1 : 8'd0;
                    default: o.result = eq ? 8'd1 : 8'd0;
                endcase
            end
            2'd1: begin
                case (ins[6:4])
                    3'd0: begin o.mem_write = 1'b1; o.r_addr1 = ins[3:2]; o.r_addr2 = ins[1:0]; end
                    3'd1: begin
                        o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                        o.w_addr = ins[3:2]; o.r_addr1 = ins[1:0];
                    end
                    3'd2: begin o.lut_write = 1'b1; o.lut_index = ins[3:0]; end
                    3'd3: begin o.lut_write = 1'b1; o.lut_sel = 1'b1; o.lut_index = ins[3:0]; end
                    3'd4: begin
                        o.reg_write = 1'b1; o.r_addr1 = 2'd3; o.w_addr = 2'd3;
                        o.result = 8'((ai / 16) * 16 + int'(ins[3:0]));
                    end
                    3'd5: begin
                        o.reg_write = 1'b1; o.r_addr1 = 2'd3; o.w_addr = 2'd3;
                        o.result = 8'(int'(ins[3:0]) * 16 + (ai % 16));
                    end
                    3'd6: begin o.reg_write = 1'b1; o.lut_to_reg = 1'b1; o.w_addr = ins[3:2]; end
                    default: ;
                endcase
            end
            2'd2: begin
                o.branch_index = ins[4:0];
                case (ins[6:5])
                    2'd0: o.branch_enable = feq;
                    2'd1: o.branch_enable = flt;
                    2'd2: o.branch_enable = feq || flt;
                    default: o.branch_enable = 1'b1;
                endcase
            end
            default: begin
                o.reg_write = 1'b1;
                if (ins[6]) begin
                    o.r_addr1 = 2'd3; o.w_addr = 2'd3;
                    amt = int'(ins[4:0]);
                end else begin
                    o.r_addr1 = ins[4:3]; o.w_addr = ins[4:3]; o.r_addr2 = ins[2:1];
                    amt = bi;
                end
                if (amt >= 8)       o.result = 8'h00;
                else if (ins[5])    o.result = 8'(ai / (1 << amt));
                else                o.result = 8'((ai * (1 << amt)) % 256);
            end
        endcase
        o.reg_write     = o.reg_write && en;
        o.mem_write     = o.mem_write && en;
        o.lut_write     = o.lut_write && en;
        o.branch_enable = o.branch_enable && en;
        return o;
    endfunction

    // Apply one vector mid-cycle, then sample outputs and build the expectation
    task automatic drive(input logic [8:0] ins, input logic [7:0] a, input logic [7:0] b,
                         input logic valid, input logic rst);
        @(negedge clk);
        bus.instr = ins; bus.rdat_a = a; bus.rdat_b = b; bus.instr_valid = valid; reset = rst;
        cur_instr = ins; cur_a = a; cur_b = b; cur_valid = valid; cur_rst = rst;
        #1;
        exp_o = model(ins, a, b, m_eq, m_lt, valid, rst);
        act_o = {bus.r_addr1, bus.r_addr2, bus.w_addr, bus.reg_write, bus.result, bus.carry,
                 bus.mem_write, bus.mem_to_reg, bus.lut_index, bus.lut_write, bus.lut_sel,
                 bus.lut_to_reg, bus.branch_enable, bus.branch_index};
    endtask

    // Advance past the rising edge and update the model flags
    task automatic tick();
        @(posedge clk);
        if (cur_rst) begin
            m_eq = 1'b0; m_lt = 1'b0;
        end else if (cur_valid && cur_instr[8:7] == 2'd0 && cur_instr[6:4] >= 3'd4) begin
            m_eq = (cur_a == cur_b);
            m_lt = cmp_lt(cur_a, cur_b);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(9'b00_011_01_10, 8'h12, 8'h34, 1'b1, 1'b1);
        n_vec++;
        if (bus.reg_write !== 1'b0) begin
            n_err++; $display("FAIL reset_reg_write: got %b want 0", bus.reg_write);
        end
        tick();
        n_vec++;
        if ({bus.equal, bus.less_than} !== 2'b00) begin
            n_err++; $display("FAIL reset_flags: got %b want 00", {bus.equal, bus.less_than});
        end
        $display("reset: flags=%b%b", bus.equal, bus.less_than);
    endtask

    task automatic test_add();
        drive(9'b00_011_01_10, 8'hF0, 8'h20, 1'b1, 1'b0);
        n_vec++;
        if ({bus.result, bus.carry, bus.reg_write, bus.w_addr} !== {8'h10, 1'b1, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL add_direct: got res=%h c=%b we=%b wa=%0d want res=10 c=1 we=1 wa=1",
                     bus.result, bus.carry, bus.reg_write, bus.w_addr);
        end
        tick();
        n_vec++;
        if ({bus.equal, bus.less_than} !== 2'b00) begin
            n_err++; $display("FAIL add_flags_hold: got %b want 00", {bus.equal, bus.less_than});
        end
        $display("add: res=%h carry=%b", bus.result, bus.carry);
    endtask

    task automatic test_slt();
        logic [7:0] want_res;
        logic       want_lt;
`ifdef SIGNED_CMP_EN
        want_res = 8'h00; want_lt = 1'b0;
`else
        want_res = 8'h01; want_lt = 1'b1;
`endif
        drive(9'b00_101_00_01, 8'd3, 8'd200, 1'b1, 1'b0);
        n_vec++;
        if (bus.result !== want_res) begin
            n_err++; $display("FAIL slt_result: got %h want %h", bus.result, want_res);
        end
        tick();
        n_vec++;
        if ({bus.equal, bus.less_than} !== {1'b0, want_lt}) begin
            n_err++; $display("FAIL slt_flags: got %b want %b", {bus.equal, bus.less_than}, {1'b0, want_lt});
        end
        $display("slt: res=%h lt=%b", want_res, bus.less_than);
    endtask

    task automatic test_branch();
        drive(9'b00_111_10_11, 8'h55, 8'h55, 1'b1, 1'b0);
        tick();
        drive(9'b10_00_01010, 8'h00, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if ({bus.branch_enable, bus.branch_index} !== {1'b1, 5'h0A}) begin
            n_err++; $display("FAIL beq_taken: got en=%b idx=%h want en=1 idx=0a",
                              bus.branch_enable, bus.branch_index);
        end
        tick();
        drive(9'b10_00_01010, 8'h00, 8'h00, 1'b1, 1'b1);
        tick();
        drive(9'b10_00_01010, 8'h00, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if (bus.branch_enable !== 1'b0) begin
            n_err++; $display("FAIL beq_after_reset: got %b want 0", bus.branch_enable);
        end
        tick();
        $display("branch: beq after reset en=%b", bus.branch_enable);
    endtask

    task automatic test_load_imm();
        drive(9'b01_100_1100, 8'h00, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if ({bus.result, bus.w_addr, bus.r_addr1} !== {8'h0C, 2'd3, 2'd3}) begin
            n_err++; $display("FAIL lil: got res=%h wa=%0d ra=%0d want 0c 3 3",
                              bus.result, bus.w_addr, bus.r_addr1);
        end
        tick();
        drive(9'b01_101_0011, 8'h0C, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if (bus.result !== 8'h3C) begin
            n_err++; $display("FAIL liu: got %h want 3c", bus.result);
        end
        tick();
        $display("load_imm: res=%h", bus.result);
    endtask

    task automatic test_shift();
        drive(9'b11_10_00011, 8'h81, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if (bus.result !== 8'h08) begin
            n_err++; $display("FAIL lsi3: got %h want 08", bus.result);
        end
        tick();
        drive(9'b11_00_01_10_0, 8'h81, 8'd9, 1'b1, 1'b0);
        n_vec++;
        if (bus.result !== 8'h00) begin
            n_err++; $display("FAIL lsl9: got %h want 00", bus.result);
        end
        tick();
        drive(9'b11_11_00001, 8'h81, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if (bus.result !== 8'h40) begin
            n_err++; $display("FAIL rsi1: got %h want 40", bus.result);
        end
        tick();
        $display("shift: rsi1 res=%h", bus.result);
    endtask

    task automatic test_gating();
        drive(9'b01_000_01_10, 8'h10, 8'h20, 1'b0, 1'b0);
        n_vec++;
        if (bus.mem_write !== 1'b0) begin
            n_err++; $display("FAIL sb_bubble: got %b want 0", bus.mem_write);
        end
        tick();
        drive(9'b00_100_00_01, 8'd1, 8'd2, 1'b1, 1'b0);
        tick();
        drive(9'b00_100_00_01, 8'd1, 8'd2, 1'b1, 1'b1);
        tick();
        n_vec++;
        if ({bus.equal, bus.less_than} !== 2'b00) begin
            n_err++; $display("FAIL sub_reset_flags: got %b want 00", {bus.equal, bus.less_than});
        end
        $display("gating: flags after reset=%b%b", bus.equal, bus.less_than);
    endtask

    task automatic test_random(input int count);
        logic [8:0] ins;
        logic [7:0] a, b;
        logic       valid, rst;
        for (int i = 0; i < count; i++) begin
            ins   = 9'($urandom);
            a     = 8'($urandom);
            b     = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            if (ins[8:7] == 2'd3 && $urandom_range(0, 1) == 0) b = 8'($urandom_range(0, 10));
            valid = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 15) == 0);
            drive(ins, a, b, valid, rst);
            n_vec++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL rand_out: instr=%b a=%h b=%h v=%b r=%b got %h want %h",
                         ins, a, b, valid, rst, act_o, exp_o);
            end
            tick();
            n_vec++;
            if ({bus.equal, bus.less_than} !== {m_eq, m_lt}) begin
                n_err++;
                $display("FAIL rand_flags: instr=%b a=%h b=%h got %b want %b",
                         ins, a, b, {bus.equal, bus.less_than}, {m_eq, m_lt});
            end
            $display("rand %0d: instr=%b a=%h b=%h res=%h flags=%b%b",
                     i, ins, a, b, bus.result, bus.equal, bus.less_than);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.instr = '0; bus.rdat_a = '0; bus.rdat_b = '0; bus.instr_valid = 1'b0;
        cur_instr = '0; cur_a = '0; cur_b = '0; cur_valid = 1'b0; cur_rst = 1'b1;
        tick();
        test_reset();
        test_add();
        test_slt();
        test_branch();
        test_load_imm();
        test_shift();
        test_gating();
        test_random(300);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
